// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and memory-strobe bundle for the load/store unit.
// slave: the LSU itself. master: the core plus data memory that surround it.
interface lsu_mem_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              i_Req;
   logic              i_We;
   logic [2:0]        i_Funct3;
   logic [ADDR_W-1:0] i_Addr;
   logic [31:0]       i_Wd;
   logic              o_Busy;
   logic              o_Ack;
   logic              o_Err;
   logic [31:0]       o_Rd;
   logic [ADDR_W-1:0] o_Mem_Addr;
   logic [31:0]       o_Mem_Wd;
   logic [3:0]        o_Mem_Wen;
   logic              o_Mem_Ren;
   logic [31:0]       i_Mem_Rd;

   modport slave (
      input  i_Req, i_We, i_Funct3, i_Addr, i_Wd, i_Mem_Rd,
      output o_Busy, o_Ack, o_Err, o_Rd, o_Mem_Addr, o_Mem_Wd, o_Mem_Wen, o_Mem_Ren
   );

   modport master (
      output i_Req, i_We, i_Funct3, i_Addr, i_Wd, i_Mem_Rd,
      input  o_Busy, o_Ack, o_Err, o_Rd, o_Mem_Addr, o_Mem_Wd, o_Mem_Wen, o_Mem_Ren
   );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: converts core byte/half/word requests into word-aligned,
// byte-enabled memory strobes and extends returned load data. Word-crossing
// accesses are split into two memory cycles or rejected, depending on
// SPLIT_MISALIGNED. One request in flight; all outputs registered.
module lsu_mem_ctrl #(
   parameter bit SPLIT_MISALIGNED = 1'b1,
   parameter int ADDR_W           = 32
) (
   input logic           i_clk,
   input logic           i_rst_n,
   lsu_mem_ctrl_if.slave bus
);

   typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAP0, CAP1, ACK} state_t;

   state_t            state_q;
   logic              busy_q, ack_q, err_q, ren_q;
   logic [31:0]       rd_q, wd_q, wd_hi_q, d0_q;
   logic [ADDR_W-1:0] addr_q, addr1_q;
   logic [3:0]        wen_q, wen_hi_q;
   logic              we_q, split_q;
   logic [2:0]        f3_q;
   logic [1:0]        off_q;

   logic [1:0]        off_d;
   logic [3:0]        base_d;
   logic [7:0]        mask_d;
   logic [63:0]       wd64_d;
   logic [ADDR_W-1:0] word0_d;
   logic              illegal_d, cross_d;

   // Shift {d1,d0} down by the byte offset, then pick and extend the lane.
   function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [63:0] d);
      logic [31:0] s;
      s = 32'(d >> {off, 3'b000});
      case (f3)
         3'b000:  return {{24{s[7]}}, s[7:0]};
         3'b001:  return {{16{s[15]}}, s[15:0]};
         3'b100:  return {24'h000000, s[7:0]};
         3'b101:  return {16'h0000, s[15:0]};
         default: return s;
      endcase
   endfunction

   // Decode the incoming request: lane mask, shifted store data, legality, crossing.
   always_comb begin
      off_d = bus.i_Addr[1:0];
      case (bus.i_Funct3[1:0])
         2'b00:   base_d = 4'b0001;
         2'b01:   base_d = 4'b0011;
         default: base_d = 4'b1111;
      endcase
      mask_d  = {4'b0000, base_d} << off_d;
      wd64_d  = {32'h0000_0000, bus.i_Wd} << {off_d, 3'b000};
      word0_d = {bus.i_Addr[ADDR_W-1:2], 2'b00};
      cross_d = |mask_d[7:4];
      case (bus.i_Funct3)
         3'b000, 3'b001, 3'b010: illegal_d = 1'b0;
         3'b100, 3'b101:         illegal_d = bus.i_We;
         default:                illegal_d = 1'b1;
      endcase
   end

   // Control FSM; every output is a register written here.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         ren_q    <= 1'b0;
         wen_q    <= '0;
         rd_q     <= '0;
         wd_q     <= '0;
         addr_q   <= '0;
         addr1_q  <= '0;
         wd_hi_q  <= '0;
         wen_hi_q <= '0;
         d0_q     <= '0;
         we_q     <= 1'b0;
         split_q  <= 1'b0;
         f3_q     <= '0;
         off_q    <= '0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         ren_q <= 1'b0;
         wen_q <= '0;
         case (state_q)
            IDLE, ACK: begin
               if (bus.i_Req) begin
                  we_q     <= bus.i_We;
                  f3_q     <= bus.i_Funct3;
                  off_q    <= off_d;
                  split_q  <= cross_d;
                  addr1_q  <= word0_d + ADDR_W'(4);
                  wd_hi_q  <= wd64_d[63:32];
                  wen_hi_q <= mask_d[7:4];
                  if (illegal_d || (cross_d && !SPLIT_MISALIGNED)) begin
                     ack_q   <= 1'b1;
                     err_q   <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ACK;
                  end else begin
                     busy_q  <= 1'b1;
                     addr_q  <= word0_d;
                     state_q <= ACC0;
                     if (bus.i_We) begin
                        wen_q <= mask_d[3:0];
                        wd_q  <= wd64_d[31:0];
                     end else begin
                        ren_q <= 1'b1;
                     end
                  end
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            ACC0: begin
               if (split_q) begin
                  addr_q  <= addr1_q;
                  state_q <= ACC1;
                  if (we_q) begin
                     wen_q <= wen_hi_q;
                     wd_q  <= wd_hi_q;
                  end else begin
                     ren_q <= 1'b1;
                  end
               end else if (we_q) begin
                  ack_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ACK;
               end else begin
                  state_q <= CAP0;
               end
            end
            ACC1: begin
               if (we_q) begin
                  ack_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ACK;
               end else begin
                  // word0 data arrives while word1 is being read
                  d0_q    <= bus.i_Mem_Rd;
                  state_q <= CAP1;
               end
            end
            CAP0: begin
               rd_q    <= extract(f3_q, off_q, {32'h0000_0000, bus.i_Mem_Rd});
               ack_q   <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ACK;
            end
            CAP1: begin
               rd_q    <= extract(f3_q, off_q, {bus.i_Mem_Rd, d0_q});
               ack_q   <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ACK;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.o_Busy     = busy_q;
   assign bus.o_Ack      = ack_q;
   assign bus.o_Err      = err_q;
   assign bus.o_Rd       = rd_q;
   assign bus.o_Mem_Addr = addr_q;
   assign bus.o_Mem_Wd   = wd_q;
   assign bus.o_Mem_Wen  = wen_q;
   assign bus.o_Mem_Ren  = ren_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a splitting instance backed by a small
// byte-enabled memory model, and a non-splitting instance with a fixed read value.
module tb_lsu_mem_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   failed = 0;
   int   cyc = 0;

   always #5 clk = ~clk;

   lsu_mem_ctrl_if #(.ADDR_W(32)) bus ();
   lsu_mem_ctrl_if #(.ADDR_W(32)) bus_ns ();

   lsu_mem_ctrl #(.SPLIT_MISALIGNED(1'b1), .ADDR_W(32)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));
   lsu_mem_ctrl #(.SPLIT_MISALIGNED(1'b0), .ADDR_W(32)) u_dut_ns (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus_ns.slave));

   // 1 KiB data memory, read data registered one cycle after Ren.
   logic [31:0] mem [0:255];
   logic [31:0] mem_rd = '0;
   assign bus.i_Mem_Rd    = mem_rd;
   assign bus_ns.i_Mem_Rd = 32'h1234_5678;

   always @(posedge clk) begin
      if (bus.o_Mem_Ren) mem_rd <= mem[bus.o_Mem_Addr[9:2]];
      for (int i = 0; i < 4; i++)
         if (bus.o_Mem_Wen[i]) mem[bus.o_Mem_Addr[9:2]][8*i +: 8] <= bus.o_Mem_Wd[8*i +: 8];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Present a request for one cycle (c0); returns at c1.
   task automatic issue(input bit ns, input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
      if (ns) begin
         bus_ns.i_We = we; bus_ns.i_Funct3 = f3; bus_ns.i_Addr = addr; bus_ns.i_Wd = wd;
         bus_ns.i_Req = 1'b1;
      end else begin
         bus.i_We = we; bus.i_Funct3 = f3; bus.i_Addr = addr; bus.i_Wd = wd;
         bus.i_Req = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.i_Req = 1'b0;
      bus_ns.i_Req = 1'b0;
      cyc = 1;
   endtask

   // Advance until o_Ack, bounded; cyc is the cycle index of the ack.
   task automatic wait_ack(input bit ns);
      while (!(ns ? bus_ns.o_Ack : bus.o_Ack) && cyc < 10) tick();
   endtask

   initial begin
      bus.i_Req = 1'b0; bus.i_We = 1'b0; bus.i_Funct3 = '0; bus.i_Addr = '0; bus.i_Wd = '0;
      bus_ns.i_Req = 1'b0; bus_ns.i_We = 1'b0; bus_ns.i_Funct3 = '0; bus_ns.i_Addr = '0;
      bus_ns.i_Wd = '0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[4] <= 32'hDEAD_BEEF;
      repeat (3) tick();
      check("reset_ctl", {bus.o_Busy, bus.o_Ack, bus.o_Err, bus.o_Mem_Ren, bus.o_Mem_Wen}, '0);
      check("reset_rd", bus.o_Rd, '0);
      check("reset_addr_wd", {bus.o_Mem_Addr, bus.o_Mem_Wd}, '0);
      rst_n = 1'b1;
      tick();

      // LW 0x10
      issue(0, 0, 3'b010, 32'h10, 0);
      check("lw_c1_strobe", {bus.o_Mem_Ren, bus.o_Mem_Wen, bus.o_Busy, bus.o_Ack}, {1'b1, 4'b0000, 1'b1, 1'b0});
      check("lw_c1_addr", bus.o_Mem_Addr, 32'h10);
      tick();
      check("lw_c2_quiet", {bus.o_Mem_Ren, bus.o_Ack}, 2'b00);
      wait_ack(0);
      check("lw_lat", cyc, 3);
      check("lw_rd", {bus.o_Err, bus.o_Busy, bus.o_Rd}, {2'b00, 32'hDEAD_BEEF});

      issue(0, 0, 3'b000, 32'h13, 0); wait_ack(0);
      check("lb_rd", bus.o_Rd, 32'hFFFF_FFDE);
      issue(0, 0, 3'b100, 32'h13, 0); wait_ack(0);
      check("lbu_rd", bus.o_Rd, 32'h0000_00DE);
      issue(0, 0, 3'b001, 32'h12, 0); wait_ack(0);
      check("lh_rd", bus.o_Rd, 32'hFFFF_DEAD);

      // SH 0x21
      issue(0, 1, 3'b001, 32'h21, 32'h0000_ABCD);
      check("sh_c1", {bus.o_Mem_Addr, bus.o_Mem_Wen, bus.o_Mem_Ren}, {32'h20, 4'b0110, 1'b0});
      check("sh_c1_wd", bus.o_Mem_Wd, 32'h00AB_CD00);
      wait_ack(0);
      check("sh_lat", cyc, 2);
      issue(0, 0, 3'b010, 32'h20, 0); wait_ack(0);
      check("sh_readback", bus.o_Rd, 32'h00AB_CD00);

      // Split loads
      mem[3] <= 32'h4433_2211; mem[4] <= 32'h8877_6655; mem[5] <= 32'h0000_00F1;
      mem[255] <= 32'hCAFE_0000; mem[0] <= 32'h0000_BEEF;
      tick();
      issue(0, 0, 3'b010, 32'h0E, 0);
      check("slw_c1", {bus.o_Mem_Ren, bus.o_Mem_Addr}, {1'b1, 32'h0C});
      tick();
      check("slw_c2", {bus.o_Mem_Ren, bus.o_Mem_Addr}, {1'b1, 32'h10});
      tick();
      check("slw_c3", {bus.o_Mem_Ren, bus.o_Ack}, 2'b00);
      wait_ack(0);
      check("slw_lat", cyc, 4);
      check("slw_rd", {bus.o_Err, bus.o_Rd}, {1'b0, 32'h6655_4433});

      issue(0, 0, 3'b010, 32'hFFFF_FFFE, 0);
      check("wrap_c1", bus.o_Mem_Addr, 32'hFFFF_FFFC);
      tick();
      check("wrap_c2", {bus.o_Mem_Ren, bus.o_Mem_Addr}, {1'b1, 32'h0});
      wait_ack(0);
      check("wrap_rd", bus.o_Rd, 32'hBEEF_CAFE);

      issue(0, 0, 3'b101, 32'h12, 0); wait_ack(0);
      check("lhu_rd", bus.o_Rd, 32'h0000_8877);
      issue(0, 0, 3'b001, 32'h13, 0); wait_ack(0);
      check("split_lh", {cyc[3:0], bus.o_Rd}, {4'd4, 32'hFFFF_F188});

      // Split store SW 0x03
      issue(0, 1, 3'b010, 32'h03, 32'hAABB_CCDD);
      check("ssw_c1", {bus.o_Mem_Addr, bus.o_Mem_Wen, bus.o_Mem_Wd}, {32'h0, 4'b1000, 32'hDD00_0000});
      tick();
      check("ssw_c2", {bus.o_Mem_Addr, bus.o_Mem_Wen, bus.o_Mem_Wd}, {32'h4, 4'b0111, 32'h00AA_BBCC});
      wait_ack(0);
      check("ssw_ack", {cyc[3:0], bus.o_Err, bus.o_Mem_Wen}, {4'd3, 1'b0, 4'b0000});
      check("ssw_mem", {mem[0], mem[1]}, {32'hDD00_BEEF, 32'h00AA_BBCC});
      issue(0, 0, 3'b010, 32'h03, 0); wait_ack(0);
      check("ssw_readback", bus.o_Rd, 32'hAABB_CCDD);

      // Non-splitting instance
      issue(1, 1, 3'b010, 32'h03, 32'hAABB_CCDD);
      check("ns_err", {bus_ns.o_Ack, bus_ns.o_Err, bus_ns.o_Mem_Wen, bus_ns.o_Mem_Ren, bus_ns.o_Busy},
            {1'b1, 1'b1, 4'b0000, 1'b0, 1'b0});
      issue(1, 0, 3'b010, 32'h10, 0); wait_ack(1);
      check("ns_lw", {cyc[3:0], bus_ns.o_Err, bus_ns.o_Rd}, {4'd3, 1'b0, 32'h1234_5678});

      // Back-to-back: load accepted in the store's ack cycle
      issue(0, 1, 3'b010, 32'h20, 32'h0102_0304); wait_ack(0);
      check("b2b_st_ack", {cyc[3:0], bus.o_Busy}, {4'd2, 1'b0});
      issue(0, 0, 3'b010, 32'h20, 0);
      check("b2b_ld_c1", {bus.o_Mem_Ren, bus.o_Busy}, 2'b11);
      wait_ack(0);
      check("b2b_ld", {cyc[3:0], bus.o_Rd}, {4'd3, 32'h0102_0304});

      // Request while busy is dropped
      issue(0, 0, 3'b010, 32'h20, 0);
      bus.i_Funct3 = 3'b011; bus.i_Req = 1'b1;
      tick();
      bus.i_Req = 1'b0;
      check("busy_ign_c2", bus.o_Ack, 1'b0);
      wait_ack(0);
      check("busy_ign_ack", {cyc[3:0], bus.o_Err, bus.o_Rd}, {4'd3, 1'b0, 32'h0102_0304});
      tick();
      check("busy_ign_noq", {bus.o_Ack, bus.o_Busy, bus.o_Mem_Ren}, 3'b000);

      // Illegal encodings
      issue(0, 0, 3'b011, 32'h10, 0);
      check("ill_f3", {bus.o_Ack, bus.o_Err, bus.o_Mem_Ren, bus.o_Mem_Wen, bus.o_Rd},
            {2'b11, 1'b0, 4'b0000, 32'h0102_0304});
      issue(0, 1, 3'b100, 32'h10, 0);
      check("ill_sbu", {bus.o_Ack, bus.o_Err, bus.o_Mem_Wen}, {2'b11, 4'b0000});

      // Reset during c1 of a split store
      mem[17] <= 32'h5A5A_5A5A;
      tick();
      issue(0, 1, 3'b010, 32'h43, 32'h1111_1111);
      check("rst_c1", {bus.o_Mem_Wen, bus.o_Busy}, {4'b1000, 1'b1});
      rst_n = 1'b0;
      #1;
      check("rst_async", {bus.o_Mem_Wen, bus.o_Busy, bus.o_Ack, bus.o_Mem_Addr, bus.o_Mem_Wd}, '0);
      #2;
      rst_n = 1'b1;
      tick();
      check("rst_no_c2", {bus.o_Mem_Wen, bus.o_Ack, bus.o_Busy}, '0);
      tick();
      check("rst_no_ack", {bus.o_Ack, bus.o_Err}, 2'b00);
      check("rst_mem_w1", mem[17], 32'h5A5A_5A5A);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
